// File: rtl/ram1r1w1c_init_pkg.sv
// Shared types and helpers for the ram1r1w1c_init storage primitive.
// Optional feature macro used by the RAM: RAM1R1W1C_PARITY_EN.
package vi_ram_pkg;

  typedef enum logic {RAM_INIT, RAM_READY} ram_state_e;

  localparam int RAM_DATA_WIDTH = 32;
  localparam int BE_W           = RAM_DATA_WIDTH / 8;

  // Even parity: stored bit makes the total count of ones in byte+bit even.
  function automatic logic par8(input logic [7:0] b);
    return ^b;
  endfunction

endpackage

// File: rtl/ram1r1w1c_init_seq.sv
// Clear sequencer: INIT/READY FSM, clear counter, init_done and the write-port mux
// that hands the array either to the sequencer or to the user write port.
module ram1r1w1c_init_seq
  import vi_ram_pkg::*;
#(
  parameter int                    ADDR_WIDTH = 4,
  parameter int                    DEPTH      = 1 << ADDR_WIDTH,
  parameter int                    DATA_WIDTH = 32,
  parameter logic [DATA_WIDTH-1:0] INIT_VAL   = '0
) (
  input  logic                    clk,
  input  logic                    rst_n,
  input  logic                    i_init_req,
  input  logic                    i_usr_we,
  input  logic [ADDR_WIDTH-1:0]   i_usr_addr,
  input  logic [DATA_WIDTH-1:0]   i_usr_data,
  input  logic [DATA_WIDTH/8-1:0] i_usr_be,
  output ram_state_e              o_state,
  output logic                    o_init_done,
  output logic                    o_mem_we,
  output logic [ADDR_WIDTH-1:0]   o_mem_addr,
  output logic [DATA_WIDTH-1:0]   o_mem_data,
  output logic [DATA_WIDTH/8-1:0] o_mem_be
);

  localparam logic [ADDR_WIDTH-1:0] LAST_ADDR = ADDR_WIDTH'(DEPTH - 1);

  ram_state_e            r_state;
  ram_state_e            w_state_nxt;
  logic [ADDR_WIDTH-1:0] r_cnt;
  logic [ADDR_WIDTH-1:0] w_cnt_nxt;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state <= RAM_INIT;
      r_cnt   <= '0;
    end else begin
      r_state <= w_state_nxt;
      r_cnt   <= w_cnt_nxt;
    end
  end

  always_comb begin
    w_state_nxt = r_state;
    w_cnt_nxt   = r_cnt;
    o_mem_we    = 1'b0;
    o_mem_addr  = i_usr_addr;
    o_mem_data  = i_usr_data;
    o_mem_be    = i_usr_be;
    case (r_state)
      RAM_INIT: begin
        o_mem_we   = 1'b1;
        o_mem_addr = r_cnt;
        o_mem_data = INIT_VAL;
        o_mem_be   = '1;
        w_cnt_nxt  = r_cnt + 1'b1;
        if (r_cnt == LAST_ADDR) begin
          w_state_nxt = RAM_READY;
          w_cnt_nxt   = '0;
        end
      end
      RAM_READY: begin
        // A user write in the same cycle as init_req still lands; the clear overwrites it.
        o_mem_we = i_usr_we;
        if (i_init_req) begin
          w_state_nxt = RAM_INIT;
          w_cnt_nxt   = '0;
        end
      end
      default: w_state_nxt = RAM_INIT;
    endcase
  end

  assign o_state     = r_state;
  assign o_init_done = (r_state == RAM_READY);

endmodule

// File: rtl/ram1r1w1c_init.sv
// 1R1W single-clock RAM with byte-lane writes, RD_LAT 1/2 read pipeline, write bypass,
// hardware clear sequencer and out-of-range flagging. Optional parity: RAM1R1W1C_PARITY_EN.
module ram1r1w1c_init
  import vi_ram_pkg::*;
#(
  parameter int                    ADDR_WIDTH = 4,
  parameter int                    DEPTH      = 1 << ADDR_WIDTH,
  parameter int                    DATA_WIDTH = 32,
  parameter int                    RD_LAT     = 1,
  parameter int                    BYPASS     = 1,
  parameter logic [DATA_WIDTH-1:0] INIT_VAL   = '0
) (
  input  logic                    clk,
  input  logic                    rst_n,
  input  logic                    init_req,
  output logic                    init_done,
  input  logic                    rden,
  input  logic [ADDR_WIDTH-1:0]   rdaddr,
  output logic [DATA_WIDTH-1:0]   rddata,
  output logic                    rdvalid,
  output logic                    rderr,
  input  logic                    wren,
  input  logic [ADDR_WIDTH-1:0]   wraddr,
  input  logic [DATA_WIDTH-1:0]   wrdata,
  input  logic [DATA_WIDTH/8-1:0] wrbe,
  output logic                    oob_err
);

  localparam int                  NB      = DATA_WIDTH / 8;
  localparam logic [ADDR_WIDTH:0] DEPTH_W = (ADDR_WIDTH + 1)'(DEPTH);

  ram_state_e            w_state;
  logic                  w_ready;
  logic                  w_mem_we;
  logic [ADDR_WIDTH-1:0] w_mem_addr;
  logic [DATA_WIDTH-1:0] w_mem_data;
  logic [NB-1:0]         w_mem_be;
  logic                  w_rd_acc, w_wr_acc, w_rd_oob, w_wr_oob, w_hit;
  logic [DATA_WIDTH-1:0] w_rd_word;
  logic                  w_rd_err;

  logic [DATA_WIDTH-1:0] r_mem [DEPTH];

  assign w_ready  = (w_state == RAM_READY);
  assign w_rd_oob = ({1'b0, rdaddr} >= DEPTH_W);
  assign w_wr_oob = ({1'b0, wraddr} >= DEPTH_W);
  assign w_rd_acc = rden & w_ready;
  assign w_wr_acc = wren & w_ready;
  assign w_hit    = (BYPASS != 0) && w_wr_acc && !w_wr_oob && !w_rd_oob && (wraddr == rdaddr);

  ram1r1w1c_init_seq #(
    .ADDR_WIDTH (ADDR_WIDTH),
    .DEPTH      (DEPTH),
    .DATA_WIDTH (DATA_WIDTH),
    .INIT_VAL   (INIT_VAL)
  ) u_seq (
    .clk         (clk),
    .rst_n       (rst_n),
    .i_init_req  (init_req),
    .i_usr_we    (wren & ~w_wr_oob),
    .i_usr_addr  (wraddr),
    .i_usr_data  (wrdata),
    .i_usr_be    (wrbe),
    .o_state     (w_state),
    .o_init_done (init_done),
    .o_mem_we    (w_mem_we),
    .o_mem_addr  (w_mem_addr),
    .o_mem_data  (w_mem_data),
    .o_mem_be    (w_mem_be)
  );

  always_ff @(posedge clk) begin
    if (w_mem_we) begin
      for (int i = 0; i < NB; i++) begin
        if (w_mem_be[i]) r_mem[w_mem_addr][8*i +: 8] <= w_mem_data[8*i +: 8];
      end
    end
  end

`ifdef RAM1R1W1C_PARITY_EN
  logic [NB-1:0] r_par [DEPTH];
  logic [NB-1:0] w_par;

  always_ff @(posedge clk) begin
    if (w_mem_we) begin
      for (int i = 0; i < NB; i++) begin
        if (w_mem_be[i]) r_par[w_mem_addr][i] <= par8(w_mem_data[8*i +: 8]);
      end
    end
  end

  // Bypassed bytes come straight from wrdata, so their parity is fresh and never flagged.
  always_comb begin
    w_rd_word = '0;
    w_rd_err  = 1'b0;
    w_par     = '0;
    if (!w_rd_oob) begin
      w_rd_word = r_mem[rdaddr];
      w_par     = r_par[rdaddr];
      for (int i = 0; i < NB; i++) begin
        if (w_hit && wrbe[i]) w_rd_word[8*i +: 8] = wrdata[8*i +: 8];
        else if (par8(w_rd_word[8*i +: 8]) != w_par[i]) w_rd_err = 1'b1;
      end
    end
  end
`else
  always_comb begin
    w_rd_word = '0;
    w_rd_err  = 1'b0;
    if (!w_rd_oob) begin
      w_rd_word = r_mem[rdaddr];
      for (int i = 0; i < NB; i++) begin
        if (w_hit && wrbe[i]) w_rd_word[8*i +: 8] = wrdata[8*i +: 8];
      end
    end
  end
`endif

  logic                  r_v1, r_e1, r_oob;
  logic [DATA_WIDTH-1:0] r_d1;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_v1  <= 1'b0;
      r_d1  <= '0;
      r_e1  <= 1'b0;
      r_oob <= 1'b0;
    end else begin
      r_v1  <= w_rd_acc;
      r_oob <= (w_rd_acc & w_rd_oob) | (w_wr_acc & w_wr_oob);
      if (w_rd_acc) begin
        r_d1 <= w_rd_word;
        r_e1 <= w_rd_err;
      end
    end
  end

  assign oob_err = r_oob;

  generate
    if (RD_LAT == 2) begin : g_lat2
      logic                  r_v2, r_e2;
      logic [DATA_WIDTH-1:0] r_d2;
      always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
          r_v2 <= 1'b0;
          r_d2 <= '0;
          r_e2 <= 1'b0;
        end else begin
          r_v2 <= r_v1;
          if (r_v1) begin
            r_d2 <= r_d1;
            r_e2 <= r_e1;
          end
        end
      end
      assign rdvalid = r_v2;
      assign rddata  = r_d2;
      assign rderr   = r_e2;
    end else begin : g_lat1
      assign rdvalid = r_v1;
      assign rddata  = r_d1;
      assign rderr   = r_e1;
    end
  endgenerate

endmodule

// File: tb/tb_ram1r1w1c_init.sv
// Randomized scoreboard bench for ram1r1w1c_init (DEPTH=12, RD_LAT=2, BYPASS=1).
module tb_ram1r1w1c_init;

  localparam int          AW       = 4;
  localparam int          DEPTH    = 12;
  localparam int          DW       = 32;
  localparam int          RD_LAT   = 2;
  localparam int          BYPASS   = 1;
  localparam logic [31:0] INIT_VAL = 32'hC3C3_1234;

  logic          clk = 1'b0;
  logic          rst_n = 1'b0;
  logic          init_req = 1'b0;
  logic          rden = 1'b0;
  logic          wren = 1'b0;
  logic [AW-1:0] rdaddr = '0;
  logic [AW-1:0] wraddr = '0;
  logic [DW-1:0] wrdata = '0;
  logic [3:0]    wrbe = '0;
  logic          init_done, rdvalid, rderr, oob_err;
  logic [DW-1:0] rddata;

  always #5 clk = ~clk;

  ram1r1w1c_init #(
    .ADDR_WIDTH (AW),
    .DEPTH      (DEPTH),
    .DATA_WIDTH (DW),
    .RD_LAT     (RD_LAT),
    .BYPASS     (BYPASS),
    .INIT_VAL   (INIT_VAL)
  ) dut (
    .clk       (clk),
    .rst_n     (rst_n),
    .init_req  (init_req),
    .init_done (init_done),
    .rden      (rden),
    .rdaddr    (rdaddr),
    .rddata    (rddata),
    .rdvalid   (rdvalid),
    .rderr     (rderr),
    .wren      (wren),
    .wraddr    (wraddr),
    .wrdata    (wrdata),
    .wrbe      (wrbe),
    .oob_err   (oob_err)
  );

  int errors = 0;
  int checks = 0;
  int cyc = 0;

  logic [DW-1:0] exp_q[$];
  logic          exp_e_q[$];
  int            exp_t_q[$];

  // Reference model: array contents, clear progress and per-word parity-damage flag.
  logic [DW-1:0] m_mem [DEPTH];
  logic          m_bad [DEPTH];
  logic          m_ready = 1'b0;
  int            m_cnt = 0;
  logic          m_oob = 1'b0;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h (cycle %0d)", name, act, exp, cyc);
    end
  endtask

  task automatic model_step(input logic rd, input logic [AW-1:0] ra, input logic wr,
                            input logic [AW-1:0] wa, input logic [31:0] wd,
                            input logic [3:0] be, input logic ir);
    logic [31:0] w;
    logic        e;
    m_oob = 1'b0;
    if (!rst_n) return;
    if (!m_ready) begin
      m_mem[m_cnt] = INIT_VAL;
      m_bad[m_cnt] = 1'b0;
      m_cnt++;
      if (m_cnt == DEPTH) m_ready = 1'b1;
      return;
    end
    if (rd) begin
      w = '0;
      e = 1'b0;
      if (int'(ra) >= DEPTH) m_oob = 1'b1;
      else begin
        w = m_mem[ra];
        e = m_bad[ra];
        if (BYPASS != 0 && wr && wa == ra) begin
          for (int i = 0; i < 4; i++) if (be[i]) w[8*i +: 8] = wd[8*i +: 8];
          if (be[0]) e = 1'b0;
        end
      end
      exp_q.push_back(w);
      exp_e_q.push_back(e);
      exp_t_q.push_back(cyc + RD_LAT - 1);
    end
    if (wr) begin
      if (int'(wa) >= DEPTH) m_oob = 1'b1;
      else begin
        for (int i = 0; i < 4; i++) if (be[i]) m_mem[wa][8*i +: 8] = wd[8*i +: 8];
        if (be[0]) m_bad[wa] = 1'b0;
      end
    end
    if (ir) begin
      m_ready = 1'b0;
      m_cnt   = 0;
    end
  endtask

  // Drive one cycle: inputs set at the negedge, model updated at the posedge.
  task automatic drive(input logic rd, input logic [AW-1:0] ra, input logic wr,
                       input logic [AW-1:0] wa, input logic [31:0] wd,
                       input logic [3:0] be, input logic ir);
    rden = rd; rdaddr = ra; wren = wr; wraddr = wa; wrdata = wd; wrbe = be; init_req = ir;
    @(posedge clk);
    cyc++;
    model_step(rd, ra, wr, wa, wd, be, ir);
    @(negedge clk);
  endtask

  task automatic idle(input int n);
    for (int i = 0; i < n; i++) drive(1'b0, '0, 1'b0, '0, '0, '0, 1'b0);
  endtask

  task automatic rd(input logic [AW-1:0] a);
    drive(1'b1, a, 1'b0, '0, '0, '0, 1'b0);
  endtask

  task automatic wr(input logic [AW-1:0] a, input logic [31:0] d, input logic [3:0] be);
    drive(1'b0, '0, 1'b1, a, d, be, 1'b0);
  endtask

  task automatic do_reset();
    rst_n = 1'b0;
    exp_q.delete();
    exp_e_q.delete();
    exp_t_q.delete();
    m_ready = 1'b0;
    m_cnt   = 0;
    m_oob   = 1'b0;
    #1;
    check("rst_rdvalid", 32'(rdvalid), 32'h0);
    check("rst_init_done", 32'(init_done), 32'h0);
    check("rst_oob_err", 32'(oob_err), 32'h0);
    check("rst_rddata", rddata, 32'h0);
    check("rst_rderr", 32'(rderr), 32'h0);
    @(negedge clk);
    idle(2);
    rst_n = 1'b1;
  endtask

  task automatic wait_ready();
    int n;
    n = 0;
    while (!init_done && n < 40) begin
      idle(1);
      n++;
    end
    checks++;
    if (!init_done) begin
      errors++;
      $display("FAIL wait_ready: init_done still %0b after %0d cycles", init_done, n);
    end
  endtask

  task automatic read_all();
    for (int a = 0; a < DEPTH; a++) rd(AW'(a));
  endtask

  // Monitor: every cycle check init_done/oob_err; pop and compare on each rdvalid.
  always @(negedge clk) begin
    if (rst_n) begin
      check("init_done", 32'(init_done), 32'(m_ready));
      check("oob_err", 32'(oob_err), 32'(m_oob));
      if (rdvalid) begin
        if (exp_q.size() == 0) begin
          checks++;
          errors++;
          $display("FAIL rdvalid_unexpected: got rddata %h expected no read", rddata);
        end else begin
          check("rddata", rddata, exp_q.pop_front());
          check("rderr", 32'(rderr), 32'(exp_e_q.pop_front()));
          check("rd_latency", 32'(cyc), 32'(exp_t_q.pop_front()));
        end
      end
    end
  end

  initial begin
    logic          r_rd, r_wr, r_ir;
    logic [AW-1:0] r_ra, r_wa;
    for (int i = 0; i < DEPTH; i++) m_bad[i] = 1'b0;

    do_reset();
    wait_ready();
    read_all();

    // Partial byte write over a zeroed word.
    wr(4'd3, 32'h0, 4'hF);
    wr(4'd3, 32'hA5A5_A5A5, 4'b0101);
    rd(4'd3);
    wr(4'd3, 32'hFFFF_FFFF, 4'h0);
    rd(4'd3);

    // Same-cycle read/write collision.
    wr(4'd7, 32'hDEAD_BEEF, 4'hF);
    drive(1'b1, 4'd7, 1'b1, 4'd7, 32'h1122_3344, 4'hF, 1'b0);
    drive(1'b1, 4'd7, 1'b1, 4'd7, 32'h5566_7788, 4'b0110, 1'b0);
    rd(4'd7);

    // Back-to-back reads.
    for (int a = 0; a < 6; a++) rd(AW'(a));

    // Out of range requests.
    drive(1'b1, 4'd14, 1'b1, 4'd13, 32'h1234_5678, 4'hF, 1'b0);
    drive(1'b1, 4'd15, 1'b0, '0, '0, '0, 1'b0);
    wr(4'd12, 32'h0BAD_0BAD, 4'hF);
    idle(3);

    // Randomized traffic with occasional re-clear.
    for (int n = 0; n < 500; n++) begin
      r_rd = 1'($urandom_range(0, 1));
      r_wr = 1'($urandom_range(0, 1));
      r_ra = AW'($urandom_range(0, 15));
      r_wa = ($urandom_range(0, 1) == 1) ? r_ra : AW'($urandom_range(0, 15));
      r_ir = ($urandom_range(0, 60) == 0);
      drive(r_rd, r_ra, r_wr, r_wa, $urandom, 4'($urandom_range(0, 15)), r_ir);
    end
    wait_ready();

    // Re-clear after writes, then reset mid-clear.
    for (int a = 0; a < DEPTH; a++) wr(AW'(a), $urandom, 4'hF);
    drive(1'b1, 4'd2, 1'b0, '0, '0, '0, 1'b1);
    idle(5);
    do_reset();
    wait_ready();
    read_all();

`ifdef RAM1R1W1C_PARITY_EN
    dut.r_par[5][0] = ~dut.r_par[5][0];
    m_bad[5] = 1'b1;
    rd(4'd5);
    drive(1'b1, 4'd5, 1'b1, 4'd5, 32'h0000_0077, 4'h1, 1'b0);
    rd(4'd5);
`endif

    idle(RD_LAT + 3);
    checks++;
    if (exp_q.size() != 0) begin
      errors++;
      $display("FAIL drain: got %0d reads outstanding expected 0", exp_q.size());
    end

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
